// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUControl codes, op legality check and arbiter FSM states
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU shared by the arbiter's requesters
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            ALU_SLL:  result = src_a << shamt;
            ALU_SRL:  result = src_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt);
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_any
);

    always_comb begin
        int c;
        logic [IDXW-1:0] ci;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        c         = 0;
        ci        = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            ci = IDXW'(c);
            if (!grant_any && req[ci]) begin
                grant_any     = 1'b1;
                grant[ci]     = 1'b1;
                grant_idx     = ci;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between NREQ requesters, one op at a time
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*4-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic [3:0]            alu_ctrl,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_t       state_q, state_d;
    logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]  id_q, id_d;
    logic [3:0]       op_q, op_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

    logic [NREQ-1:0]  gnt;
    logic [IDXW-1:0]  gnt_idx;
    logic             gnt_any;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    assign sel_op = req_op[int'(gnt_idx)*4 +: 4];
    assign sel_a  = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign sel_b  = req_b[int'(gnt_idx)*WIDTH +: WIDTH];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        op_d         = op_q;
        alu_ctrl_d   = '0;
        alu_a_d      = '0;
        alu_b_d      = '0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                // ready must read zero while reset is held, even with requests pending
                req_ready = reset ? '0 : gnt;
                if (gnt_any) begin
                    id_d    = gnt_idx;
                    op_d    = sel_op;
                    state_d = EXEC;
                    if (is_legal_op(sel_op)) begin
                        alu_ctrl_d = sel_op;
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                    end
                end
            end
            EXEC: begin
                state_d           = RESP;
                rsp_valid_d       = '0;
                rsp_valid_d[id_q] = 1'b1;
                if (is_legal_op(op_q)) begin
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    rsp_err_d    = 1'b0;
                end else begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b0;
                    rsp_err_d    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready[id_q]) begin
                    state_d     = IDLE;
                    rsp_valid_d = '0;
                    rr_ptr_d    = (id_q == IDXW'(NREQ-1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_q         <= '0;
            alu_ctrl_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            op_q         <= op_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_ctrl   = alu_ctrl_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter wired to the real alu
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*4-1:0] req_op = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [W-1:0]   rsp_result;
    logic           rsp_zero;
    logic           rsp_err;
    logic [3:0]     alu_ctrl;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_result;
    logic           alu_zero;

    alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    alu #(.WIDTH(W)) u_alu (
        .alu_ctrl (alu_ctrl),
        .src_a    (alu_a),
        .src_b    (alu_b),
        .result   (alu_result),
        .zero     (alu_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {err, zero, result} from the instruction-set meaning of each code
    function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        int          sh;
        sh = int'(b % 32);
        r  = 0;
        e  = 1'b0;
        case (op)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0111: r = a & b;
            4'b0110: r = a | b;
            4'b0100: r = a ^ b;
            4'b0010: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0001: r = a << sh;
            4'b0101: r = a >> sh;
            4'b1101: r = a[31] ? ~((~a) >> sh) : (a >> sh);
            default: e = 1'b1;
        endcase
        return {e, (!e && r == 0), r};
    endfunction

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          hs_cyc;
    } exp_t;

    exp_t sbq[$];
    int   m_ptr = 0;
    bit   busy  = 0;

    // monitor: predicts grants, ALU drive and responses; samples on the falling edge
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic [N-1:0] oh;
        logic [67:0]  exp_alu;
        exp_t         e;
        int           c;
        int           gi;
        if (reset) begin
            chk("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_ctrl, alu_a, alu_b}, '0);
            sbq.delete();
            busy  = 0;
            m_ptr = 0;
        end else begin
            exp_alu = '0;
            if (sbq.size() > 0 && cyc == sbq[0].hs_cyc + 1 && !sbq[0].err)
                exp_alu = {sbq[0].op, sbq[0].a, sbq[0].b};
            chk("alu_inputs", {alu_ctrl, alu_a, alu_b}, exp_alu);

            exp_rdy = '0;
            gi      = 0;
            if (!busy) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (exp_rdy == 0 && req_valid[c]) begin
                        exp_rdy[c] = 1'b1;
                        gi         = c;
                    end
                end
            end
            chk("req_ready", req_ready, exp_rdy);
            if (!busy && exp_rdy != 0) begin
                e.id     = gi;
                e.op     = req_op[4*gi +: 4];
                e.a      = req_a[W*gi +: W];
                e.b      = req_b[W*gi +: W];
                {e.err, e.zero, e.res} = model(e.op, e.a, e.b);
                e.hs_cyc = cyc;
                sbq.push_back(e);
                busy = 1;
            end

            if (sbq.size() == 0 || cyc < sbq[0].hs_cyc + 2) begin
                chk("rsp_valid_quiet", rsp_valid, '0);
            end else begin
                oh = '0;
                oh[sbq[0].id] = 1'b1;
                chk("rsp_valid_route", rsp_valid, oh);
                chk("rsp_data", {rsp_result, rsp_zero, rsp_err}, {sbq[0].res, sbq[0].zero, sbq[0].err});
                if (rsp_ready[sbq[0].id]) begin
                    m_ptr = (sbq[0].id + 1) % N;
                    void'(sbq.pop_front());
                    busy = 0;
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } wreq_t;

    wreq_t wq0[$];
    wreq_t wq1[$];
    int    rsp_prob    = 100;
    bit    reset_on_hs = 0;

    task automatic push(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        wreq_t w;
        w.op = op;
        w.a  = a;
        w.b  = b;
        if (r == 0) wq0.push_back(w);
        else        wq1.push_back(w);
    endtask

    // one clock of stimulus: hold each request until its handshake, then present the next
    task automatic step();
        logic [N-1:0] hs;
        wreq_t        w;
        bit           have;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (reset_on_hs && hs != 0) begin
            reset       = 1'b1;
            reset_on_hs = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (hs[i]) req_valid[i] = 1'b0;
            if (!req_valid[i]) begin
                have = 0;
                if (i == 0 && wq0.size() > 0) begin w = wq0.pop_front(); have = 1; end
                if (i == 1 && wq1.size() > 0) begin w = wq1.pop_front(); have = 1; end
                if (have) begin
                    req_valid[i]     = 1'b1;
                    req_op[4*i +: 4] = w.op;
                    req_a[W*i +: W]  = w.a;
                    req_b[W*i +: W]  = w.b;
                end
            end
            rsp_ready[i] = ($urandom_range(0, 99) < rsp_prob);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((wq0.size() > 0 || wq1.size() > 0 || req_valid != 0 || sbq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_within_budget", (n < budget), 1);
    endtask

    logic [3:0] legal_ops [10];

    initial begin
        legal_ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA};

        repeat (3) step();
        reset = 1'b0;
        rsp_prob = 100;

        push(0, ALU_ADD, 32'd1, 32'd1);
        drain(50);
        push(0, ALU_SUB, 32'd5, 32'd5);
        drain(50);

        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        push(0, ALU_SUB, 32'd3, 32'd1);
        push(1, ALU_AND, 32'd3, 32'd1);
        push(0, ALU_SUB, 32'd3, 32'd1);
        push(1, ALU_AND, 32'd3, 32'd1);
        drain(100);

        rsp_prob = 0;
        push(1, ALU_SLT, 32'hFFFF_FFFD, 32'd1);
        repeat (3) step();
        push(0, ALU_ADD, 32'd7, 32'd8);
        repeat (5) step();
        rsp_prob = 100;
        drain(100);

        push(0, ALU_SRA,  32'hFFFF_FC18, 32'd3);
        push(0, ALU_SRL,  32'hFFFF_FC18, 32'd2);
        push(0, ALU_SLTU, 32'hFFFF_FFFD, 32'd1);
        push(0, 4'b1111,  32'h0000_1234, 32'h0000_5678);
        push(0, ALU_ADD,  32'd2, 32'd3);
        drain(200);

        push(0, ALU_ADD, 32'd4, 32'd4);
        drain(50);
        push(0, ALU_XOR, 32'h0000_00F0, 32'h0000_000F);
        reset_on_hs = 1;
        repeat (3) step();
        push(0, ALU_OR,  32'd1, 32'd2);
        push(1, ALU_ADD, 32'd9, 32'd9);
        step();
        reset = 1'b0;
        drain(100);

        rsp_prob = 70;
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = ($urandom_range(0, 9) == 0) ? 4'(4'b1001 + $urandom_range(0, 1) * 4'b0110)
                                             : legal_ops[$urandom_range(0, 9)];
            a  = $urandom;
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            push(int'($urandom_range(0, 1)), op, a, b);
            repeat ($urandom_range(0, 3)) step();
        end
        drain(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
